// File: rtl/ring_mem_ctrl_pkg.sv
// ring_mem_ctrl_pkg
//   Shared definitions for the ring memory controller: ring slot-type codes,
//   line geometry, the queued request record and the command FSM states.
//   The slot-type codes must stay in step with the DCache ring drivers.
package ring_mem_ctrl_pkg;

    localparam logic [3:0] SLOT_TOKEN     = 4'd1;
    localparam logic [3:0] SLOT_ADDRESS   = 4'd2;
    localparam logic [3:0] SLOT_WRITEDATA = 4'd3;
    localparam logic [3:0] SLOT_READDATA  = 4'd4;
    localparam logic [3:0] SLOT_NULL      = 4'd7;

    localparam int unsigned LINE_WORDS = 8;
    localparam int unsigned ADDR_W     = 28;
    localparam int unsigned SRC_W      = 4;

    // Address-slot field positions
    localparam int unsigned ADDR_KIND_HI = 31;  // [31:30] must be 00 for memory traffic
    localparam int unsigned ADDR_KIND_LO = 30;
    localparam int unsigned ADDR_RD_BIT  = 28;  // 1 = read, 0 = write

    typedef struct packed {
        logic              write;
        logic [SRC_W-1:0]  src;
        logic [ADDR_W-1:0] addr;
    } memReq_t;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        WDATA
    } ctrlState_t;

    function automatic logic isMemAddress(input logic [3:0] slotType, input logic [31:0] payload);
        return (slotType == SLOT_ADDRESS) && (payload[ADDR_KIND_HI:ADDR_KIND_LO] == 2'b00);
    endfunction

endpackage

// File: rtl/ring_mem_ctrl_fifo.sv
// ring_fifo
//   Synchronous FIFO, first-word-fall-through read port.
//   clock, reset      : system clock, synchronous active-high reset
//   push / pushData   : write strobe and data (ignored when full unless popping)
//   pop / popData     : read strobe and head word (pop on empty is ignored)
//   empty / full      : occupancy flags
//   DEPTH must be a power of 2 so the pointers wrap naturally.
module ring_fifo #(
    parameter int unsigned W     = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] pushData,
    input  logic         pop,
    output logic [W-1:0] popData,
    output logic         empty,
    output logic         full
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wrPtr;
    logic [AW-1:0] rdPtr;
    logic [AW:0]   count;
    logic          doPush;
    logic          doPop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign doPop   = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign doPush  = push && (!full || doPop);
    assign popData = mem[rdPtr];

    always_ff @(posedge clock) begin
        if (doPush) begin
            mem[wrPtr] <= pushData;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (doPop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ring_mem_ctrl.sv
// ring_mem_ctrl
//   Ring-tail endpoint that absorbs DCache line traffic and services it
//   against a line-oriented DRAM backend.
//   clock, reset            : system clock, synchronous active-high reset
//   RingIn/SlotTypeIn/SourceIn    : incoming ring slot
//   RingOut/SlotTypeOut/SourceOut : forwarded slot (consumed slots become Null)
//   RDreturn/RDdest         : read-return word and its destination core (0 = none)
//   memCmd*                 : backend line command (valid/ready handshake)
//   memWrData/memWrEn       : write words, 8 per write command
//   memRdData/memRdValid    : read words, 8 per read, in command order
//   ovfErr                  : sticky request/write-data FIFO overflow
module ring_mem_ctrl
    import ring_mem_ctrl_pkg::*;
#(
    parameter int unsigned REQ_DEPTH = 8,
    parameter int unsigned WD_DEPTH  = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] RingIn,
    input  logic [3:0]  SlotTypeIn,
    input  logic [3:0]  SourceIn,
    output logic [31:0] RingOut,
    output logic [3:0]  SlotTypeOut,
    output logic [3:0]  SourceOut,
    output logic [31:0] RDreturn,
    output logic [3:0]  RDdest,
    output logic        memCmdValid,
    input  logic        memCmdReady,
    output logic        memCmdWrite,
    output logic [27:0] memCmdAddr,
    output logic [31:0] memWrData,
    output logic        memWrEn,
    input  logic [31:0] memRdData,
    input  logic        memRdValid,
    output logic        ovfErr
);

    memReq_t     reqPushData;
    memReq_t     reqHead;
    logic        reqPush, reqPop, reqEmpty, reqFull;
    logic [31:0] wdHead;
    logic        wdPush, wdPop, wdEmpty, wdFull;
    logic [3:0]  destHead;
    logic        destPush, destPop, destEmpty, destFull;

    ctrlState_t  state;
    logic [2:0]  wrBeat;
    logic [2:0]  rdBeat;
    logic        cmdFire;

    // Ring decode
    assign reqPush     = isMemAddress(SlotTypeIn, RingIn);
    assign wdPush      = (SlotTypeIn == SLOT_WRITEDATA);
    assign reqPushData = '{write: ~RingIn[ADDR_RD_BIT], src: SourceIn, addr: RingIn[ADDR_W-1:0]};

    // FIFO control
    assign cmdFire  = (state == CMD) && memCmdValid && memCmdReady;
    assign reqPop   = cmdFire;
    assign destPush = cmdFire && !memCmdWrite;
    assign wdPop    = (state == WDATA) && !wdEmpty;
    assign destPop  = memRdValid && (rdBeat == 3'd7);

    ring_fifo #(.W($bits(memReq_t)), .DEPTH(REQ_DEPTH)) reqFifo (
        .clock(clock), .reset(reset),
        .push(reqPush), .pushData(reqPushData),
        .pop(reqPop), .popData(reqHead),
        .empty(reqEmpty), .full(reqFull)
    );

    ring_fifo #(.W(32), .DEPTH(WD_DEPTH)) wdFifo (
        .clock(clock), .reset(reset),
        .push(wdPush), .pushData(RingIn),
        .pop(wdPop), .popData(wdHead),
        .empty(wdEmpty), .full(wdFull)
    );

    ring_fifo #(.W(4), .DEPTH(4)) destFifo (
        .clock(clock), .reset(reset),
        .push(destPush), .pushData(reqHead.src),
        .pop(destPop), .popData(destHead),
        .empty(destEmpty), .full(destFull)
    );

    // Ring stage
    always_ff @(posedge clock) begin
        if (reset || reqPush || wdPush) begin
            RingOut     <= '0;
            SlotTypeOut <= SLOT_NULL;
            SourceOut   <= '0;
        end else begin
            RingOut     <= RingIn;
            SlotTypeOut <= SlotTypeIn;
            SourceOut   <= SourceIn;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ovfErr <= 1'b0;
        end else if ((reqPush && reqFull && !reqPop) || (wdPush && wdFull && !wdPop)) begin
            ovfErr <= 1'b1;
        end
    end

    // Command FSM. The command is latched from the REQ head when memCmdValid
    // rises; a read only raises it once DEST has room, and since only this
    // FSM pushes DEST, that room cannot vanish before the handshake.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            memCmdValid <= 1'b0;
            memCmdWrite <= 1'b0;
            memCmdAddr  <= '0;
            memWrEn     <= 1'b0;
            memWrData   <= '0;
            wrBeat      <= '0;
        end else begin
            memWrEn <= 1'b0;
            case (state)
                IDLE: begin
                    if (!reqEmpty) begin
                        state <= CMD;
                    end
                end
                CMD: begin
                    if (!memCmdValid) begin
                        if (reqHead.write || !destFull) begin
                            memCmdValid <= 1'b1;
                            memCmdWrite <= reqHead.write;
                            memCmdAddr  <= reqHead.addr;
                        end
                    end else if (memCmdReady) begin
                        memCmdValid <= 1'b0;
                        wrBeat      <= '0;
                        state       <= memCmdWrite ? WDATA : IDLE;
                    end
                end
                WDATA: begin
                    if (!wdEmpty) begin
                        memWrEn   <= 1'b1;
                        memWrData <= wdHead;
                        wrBeat    <= wrBeat + 1'b1;
                        if (wrBeat == 3'd7) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Return path
    always_ff @(posedge clock) begin
        if (reset) begin
            RDreturn <= '0;
            RDdest   <= '0;
            rdBeat   <= '0;
        end else if (memRdValid) begin
            RDreturn <= memRdData;
            RDdest   <= destEmpty ? 4'd0 : destHead;
            rdBeat   <= rdBeat + 1'b1;
        end else begin
            RDreturn <= '0;
            RDdest   <= '0;
        end
    end

endmodule

// File: tb/tb_ring_mem_ctrl.sv
// tb_ring_mem_ctrl
//   Self-checking bench for ring_mem_ctrl: table-driven ring slots, a
//   backend model that answers line reads, and scoreboards for commands,
//   write words and read returns.
module tb_ring_mem_ctrl;

    localparam logic [3:0] T_TOKEN = 4'd1;
    localparam logic [3:0] T_ADDR  = 4'd2;
    localparam logic [3:0] T_WD    = 4'd3;
    localparam logic [3:0] T_RD    = 4'd4;
    localparam logic [3:0] T_NULL  = 4'd7;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] RingIn;
    logic [3:0]  SlotTypeIn;
    logic [3:0]  SourceIn;
    logic [31:0] RingOut;
    logic [3:0]  SlotTypeOut;
    logic [3:0]  SourceOut;
    logic [31:0] RDreturn;
    logic [3:0]  RDdest;
    logic        memCmdValid;
    logic        memCmdReady;
    logic        memCmdWrite;
    logic [27:0] memCmdAddr;
    logic [31:0] memWrData;
    logic        memWrEn;
    logic [31:0] memRdData;
    logic        memRdValid;
    logic        ovfErr;

    ring_mem_ctrl #(.REQ_DEPTH(8), .WD_DEPTH(64)) dut (
        .clock(clock), .reset(reset),
        .RingIn(RingIn), .SlotTypeIn(SlotTypeIn), .SourceIn(SourceIn),
        .RingOut(RingOut), .SlotTypeOut(SlotTypeOut), .SourceOut(SourceOut),
        .RDreturn(RDreturn), .RDdest(RDdest),
        .memCmdValid(memCmdValid), .memCmdReady(memCmdReady),
        .memCmdWrite(memCmdWrite), .memCmdAddr(memCmdAddr),
        .memWrData(memWrData), .memWrEn(memWrEn),
        .memRdData(memRdData), .memRdValid(memRdValid),
        .ovfErr(ovfErr)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0]  typ;
        logic [3:0]  src;
        logic [31:0] pay;
        logic [3:0]  eTyp;
        logic [3:0]  eSrc;
        logic [31:0] ePay;
    } vec_t;

    typedef struct {
        logic        write;
        logic [3:0]  src;
        logic [27:0] addr;
    } cmd_t;

    typedef struct {
        logic [3:0]  dest;
        logic [31:0] data;
    } ret_t;

    int vectors = 0;
    int miscompares = 0;

    cmd_t        expCmd[$];
    cmd_t        pendQ[$];
    ret_t        retQ[$];
    logic [31:0] wdQ[$];
    logic        readyEn = 1'b1;
    logic [2:0]  retBeat = '0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void failNote(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s at %0t", name, $time);
    endfunction

    function automatic vec_t mk(input logic [3:0] t, input logic [3:0] s, input logic [31:0] p,
                                input logic [3:0] et, input logic [3:0] es, input logic [31:0] ep);
        vec_t v;
        v.typ = t; v.src = s; v.pay = p; v.eTyp = et; v.eSrc = es; v.ePay = ep;
        return v;
    endfunction

    // Drive one slot for a cycle, record what the controller must do with it,
    // and check the forwarded slot one cycle later.
    task automatic applySlot(input vec_t v, input string name);
        logic [31:0] p;
        @(negedge clock);
        SlotTypeIn = v.typ;
        SourceIn   = v.src;
        RingIn     = v.pay;
        p = v.pay;
        if (v.typ == T_WD) wdQ.push_back(p);
        if (v.typ == T_ADDR && p[31:30] == 2'b00)
            expCmd.push_back('{write: ~p[28], src: v.src, addr: p[27:0]});
        @(posedge clock);
        #1;
        check({name, ".type"}, 32'(SlotTypeOut), 32'(v.eTyp));
        check({name, ".src"},  32'(SourceOut),   32'(v.eSrc));
        check({name, ".data"}, RingOut,          v.ePay);
        SlotTypeIn = T_NULL;
        SourceIn   = '0;
        RingIn     = '0;
    endtask

    task automatic nullSlot(input vec_t v, input string name);
        applySlot(mk(v.typ, v.src, v.pay, T_NULL, 4'd0, 32'd0), name);
    endtask

    task automatic checkResetValues(input string tag);
        check({tag, ".RingOut"},     RingOut,             32'd0);
        check({tag, ".SlotTypeOut"}, 32'(SlotTypeOut),    32'(T_NULL));
        check({tag, ".SourceOut"},   32'(SourceOut),      32'd0);
        check({tag, ".RDreturn"},    RDreturn,            32'd0);
        check({tag, ".RDdest"},      32'(RDdest),         32'd0);
        check({tag, ".memCmdValid"}, 32'(memCmdValid),    32'd0);
        check({tag, ".memWrEn"},     32'(memWrEn),        32'd0);
        check({tag, ".ovfErr"},      32'(ovfErr),         32'd0);
    endtask

    task automatic drain(input int maxCycles, input string tag);
        bit done = 0;
        for (int i = 0; i < maxCycles && !done; i++) begin
            @(posedge clock);
            #2;
            done = (expCmd.size() == 0) && (pendQ.size() == 0) && (retQ.size() == 0) &&
                   (wdQ.size() == 0) && !memCmdValid && !memWrEn;
        end
        if (!done) begin
            failNote({tag, ".drain timeout"});
            expCmd.delete(); pendQ.delete(); retQ.delete(); wdQ.delete();
        end
    endtask

    // Backend model: accepts commands, checks them against arrival order and
    // returns 8 words per read, one per cycle, tagged with the line address.
    initial begin
        cmd_t        c;
        logic [31:0] d;
        memCmdReady = 1'b0;
        memRdValid  = 1'b0;
        memRdData   = '0;
        forever begin
            @(negedge clock);
            if (pendQ.size() > 0 && !reset) begin
                d = {1'b0, pendQ[0].addr, retBeat};
                memRdData  = d;
                memRdValid = 1'b1;
                retQ.push_back('{dest: pendQ[0].src, data: d});
                if (retBeat == 3'd7) void'(pendQ.pop_front());
                retBeat = retBeat + 3'd1;
            end else begin
                memRdValid = 1'b0;
            end
            memCmdReady = readyEn;
            if (!reset && memCmdValid && memCmdReady) begin
                if (expCmd.size() == 0) begin
                    failNote("memCmd unexpected command");
                end else begin
                    c = expCmd.pop_front();
                    check("memCmdWrite", 32'(memCmdWrite), 32'(c.write));
                    check("memCmdAddr",  32'(memCmdAddr),  32'(c.addr));
                    if (!c.write) pendQ.push_back(c);
                end
            end
        end
    end

    // Return and write-word monitor.
    initial begin
        ret_t r;
        forever begin
            @(posedge clock);
            #1;
            if (!reset) begin
                if (retQ.size() > 0) begin
                    r = retQ.pop_front();
                    check("RDdest",   32'(RDdest), 32'(r.dest));
                    check("RDreturn", RDreturn,    r.data);
                end else begin
                    check("RDdest idle", 32'(RDdest), 32'd0);
                end
                if (memWrEn) begin
                    if (wdQ.size() == 0) failNote("memWrEn unexpected word");
                    else check("memWrData", memWrData, wdQ.pop_front());
                end
            end
        end
    end

    vec_t tbl[8];

    initial begin
        int n;
        tbl[0] = mk(T_ADDR,  4'd3,  32'h1000_0040, T_NULL,  4'd0,  32'd0);
        tbl[1] = mk(T_TOKEN, 4'd2,  32'h0000_0005, T_TOKEN, 4'd2,  32'h0000_0005);
        tbl[2] = mk(T_RD,    4'd6,  32'hDEAD_BEEF, T_RD,    4'd6,  32'hDEAD_BEEF);
        tbl[3] = mk(T_ADDR,  4'd4,  32'h8000_0001, T_ADDR,  4'd4,  32'h8000_0001);
        tbl[4] = mk(T_ADDR,  4'd9,  32'h4000_0100, T_ADDR,  4'd9,  32'h4000_0100);
        tbl[5] = mk(T_NULL,  4'd0,  32'd0,         T_NULL,  4'd0,  32'd0);
        tbl[6] = mk(T_ADDR,  4'd7,  32'h3000_0080, T_NULL,  4'd0,  32'd0);
        tbl[7] = mk(T_TOKEN, 4'd15, 32'hFFFF_FFFF, T_TOKEN, 4'd15, 32'hFFFF_FFFF);

        reset = 1'b1;
        SlotTypeIn = T_NULL;
        SourceIn   = '0;
        RingIn     = '0;
        repeat (2) @(posedge clock);
        #1;
        checkResetValues("reset");
        @(negedge clock);
        reset = 1'b0;

        // Ring decode table, including the core-3 read of line 0x40.
        for (int i = 0; i < 8; i++) applySlot(tbl[i], $sformatf("tbl%0d", i));
        drain(200, "table");

        // Core 5 write: 8 data words then the address; all 9 slots consumed.
        for (int i = 0; i < 8; i++)
            nullSlot(mk(T_WD, 4'd5, 32'hA5A5_0000 + 32'(i), 0, 0, 0), $sformatf("wr.wd%0d", i));
        nullSlot(mk(T_ADDR, 4'd5, 32'h0000_0123, 0, 0, 0), "wr.addr");
        drain(200, "write");

        // Backend not ready while three reads queue up.
        readyEn = 1'b0;
        nullSlot(mk(T_ADDR, 4'd1, 32'h1000_0200, 0, 0, 0), "stall.r1");
        nullSlot(mk(T_ADDR, 4'd2, 32'h1000_0300, 0, 0, 0), "stall.r2");
        nullSlot(mk(T_ADDR, 4'd4, 32'h1000_0400, 0, 0, 0), "stall.r4");
        repeat (10) @(negedge clock);
        check("stall.noCmdYet", 32'(expCmd.size()), 32'd3);
        readyEn = 1'b1;
        drain(300, "stall");

        // Nine reads into an 8-deep request queue with nothing issuing.
        readyEn = 1'b0;
        for (int i = 0; i < 9; i++)
            nullSlot(mk(T_ADDR, 4'(i + 1), 32'h1000_1000 + 32'(i * 8), 0, 0, 0), $sformatf("ovf.r%0d", i));
        // the ninth request finds the queue full and is lost
        void'(expCmd.pop_back());
        repeat (3) @(posedge clock);
        #1;
        check("ovf.set", 32'(ovfErr), 32'd1);
        readyEn = 1'b1;
        drain(1000, "ovf");
        check("ovf.sticky", 32'(ovfErr), 32'd1);

        // Reset in the middle of a write burst.
        for (int i = 0; i < 8; i++)
            nullSlot(mk(T_WD, 4'd5, 32'hC0DE_0000 + 32'(i), 0, 0, 0), $sformatf("rst.wd%0d", i));
        nullSlot(mk(T_ADDR, 4'd5, 32'h0000_0200, 0, 0, 0), "rst.addr");
        n = 0;
        for (int i = 0; i < 100 && n < 4; i++) begin
            @(posedge clock);
            #2;
            if (memWrEn) n++;
        end
        check("rst.beat4reached", 32'(n), 32'd4);
        @(negedge clock);
        reset = 1'b1;
        wdQ.delete(); expCmd.delete(); pendQ.delete(); retQ.delete();
        @(posedge clock);
        #1;
        checkResetValues("midreset");
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock);
            #1;
            check("postreset.noCmd", 32'(memCmdValid), 32'd0);
        end
        nullSlot(mk(T_ADDR, 4'd3, 32'h1000_0500, 0, 0, 0), "fresh.read");
        for (int i = 0; i < 8; i++)
            nullSlot(mk(T_WD, 4'd6, 32'h5EED_0000 + 32'(i), 0, 0, 0), $sformatf("fresh.wd%0d", i));
        nullSlot(mk(T_ADDR, 4'd6, 32'h0000_0600, 0, 0, 0), "fresh.write");
        drain(300, "fresh");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
